// File: rtl/ula_load_store_pkg.sv
// ula_pkg: shared definitions for the ULA load/store sequencer.
//   - ULA opcode constants
//   - physical matrix geometry (MAX_DIM x MAX_DIM, ELEM_W-bit elements)
//   - sequencer state enum
//   - needs_b(): whether an opcode consumes a second operand matrix
package ula_pkg;

    localparam int unsigned MAX_DIM = 5;
    localparam int unsigned ELEM_W  = 8;

    localparam logic [2:0] OP_SOMA   = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_MUL    = 3'b010;
    localparam logic [2:0] OP_ESC    = 3'b011;
    localparam logic [2:0] OP_TRANSP = 3'b100;
    localparam logic [2:0] OP_OPOSTA = 3'b101;
    localparam logic [2:0] OP_DET    = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_EXEC,
        ST_STORE
    } state_t;

    function automatic logic needs_b(input logic [2:0] op);
        return (op == OP_SOMA) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/ula_load_store_if.sv
// ula_load_store_if: host-side byte interface of the ULA sequencer.
//   cmd_*  : command channel (opcode, dimension, scalar) with valid/ready
//   in_*   : operand element stream into the sequencer
//   out_*  : result element stream out of the sequencer, out_last on final
// Modports: master = host side, slave = sequencer side.
interface ula_load_store_if;
    import ula_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_opcode;
    logic [7:0]        cmd_tamanho;
    logic [7:0]        cmd_escalar;

    logic              in_valid;
    logic              in_ready;
    logic [ELEM_W-1:0] in_data;

    logic              out_valid;
    logic              out_ready;
    logic [ELEM_W-1:0] out_data;
    logic              out_last;

    modport master (
        output cmd_valid, cmd_opcode, cmd_tamanho, cmd_escalar,
        output in_valid, in_data,
        output out_ready,
        input  cmd_ready, in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_tamanho, cmd_escalar,
        input  in_valid, in_data,
        input  out_ready,
        output cmd_ready, in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/ula_load_store_indice_matriz.sv
// indice_matriz: row/column walker over an n x n region of the fixed
// MAX_DIM x MAX_DIM layout, row-major, column wrapping at n-1.
//   clk, rst     : clock, async active-high reset
//   i_clear      : return to (0,0); wins over i_step
//   i_step       : advance one element
//   i_n          : active dimension n (2..MAX_DIM)
//   o_idx        : flat index r*MAX_DIM+c of the current element
//   o_nxt_idx    : flat index of the element after one step
//   o_last       : current element is (n-1,n-1), i.e. the n*n-th one
//   o_nxt_last   : the element after one step is (n-1,n-1)
module indice_matriz
    import ula_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_step,
    input  logic [2:0] i_n,
    output logic [4:0] o_idx,
    output logic [4:0] o_nxt_idx,
    output logic       o_last,
    output logic       o_nxt_last
);

    localparam logic [4:0] STRIDE = 5'(MAX_DIM);

    logic [2:0] r_row;
    logic [2:0] r_col;
    logic [2:0] w_lim;
    logic       w_wrap;
    logic [2:0] w_nxt_row;
    logic [2:0] w_nxt_col;

    assign w_lim     = i_n - 3'd1;
    assign w_wrap    = (r_col == w_lim);
    assign w_nxt_col = w_wrap ? 3'd0 : r_col + 3'd1;
    assign w_nxt_row = w_wrap ? r_row + 3'd1 : r_row;

    assign o_idx      = {2'b00, r_row} * STRIDE + {2'b00, r_col};
    assign o_nxt_idx  = {2'b00, w_nxt_row} * STRIDE + {2'b00, w_nxt_col};
    assign o_last     = (r_row == w_lim) && w_wrap;
    assign o_nxt_last = (w_nxt_row == w_lim) && (w_nxt_col == w_lim);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_step) begin
            r_row <= w_nxt_row;
            r_col <= w_nxt_col;
        end
    end

endmodule

// File: rtl/ula_load_store.sv
// ula_load_store: command/operand/result sequencer around the matrix ULA.
//   clk, rst            : clock, async active-high reset
//   bus (slave)         : cmd / in / out byte handshakes
//   matriz1, matriz2    : operand registers, element (r,c) at [(r*5+c)*8 +: 8]
//   opcode/escalar/tamanho : registered copy of the accepted command
//   resultado           : ULA result, captured on the last EXEC cycle
//   busy                : sequencer not idle
//   erro                : one-cycle pulse on a rejected command
module ula_load_store #(
    parameter int unsigned EXEC_CYCLES = 4,
    parameter int unsigned MAX_DIM     = 5
) (
    input  logic                                       clk,
    input  logic                                       rst,
    ula_load_store_if.slave                            bus,
    output logic [MAX_DIM*MAX_DIM*ula_pkg::ELEM_W-1:0] matriz1,
    output logic [MAX_DIM*MAX_DIM*ula_pkg::ELEM_W-1:0] matriz2,
    output logic [2:0]                                 opcode,
    output logic [7:0]                                 escalar,
    output logic [7:0]                                 tamanho,
    input  logic [MAX_DIM*MAX_DIM*ula_pkg::ELEM_W-1:0] resultado,
    output logic                                       busy,
    output logic                                       erro
);
    import ula_pkg::*;

    localparam int unsigned MAT_W     = MAX_DIM * MAX_DIM * ELEM_W;
    localparam logic [3:0]  EXEC_LAST = 4'(EXEC_CYCLES - 1);

    state_t            r_state;
    logic [MAT_W-1:0]  r_matriz1;
    logic [MAT_W-1:0]  r_matriz2;
    logic [MAT_W-1:0]  r_result;
    logic [2:0]        r_opcode;
    logic [7:0]        r_escalar;
    logic [7:0]        r_tamanho;
    logic [3:0]        r_exec;
    logic              r_out_valid;
    logic [ELEM_W-1:0] r_out_data;
    logic              r_out_last;
    logic              r_erro;

    logic       w_cmd_fire;
    logic       w_cmd_legal;
    logic       w_loading;
    logic       w_in_fire;
    logic       w_out_fire;
    logic       w_cnt_clear;
    logic       w_cnt_step;
    logic [4:0] w_idx;
    logic [4:0] w_nxt_idx;
    logic       w_last;
    logic       w_nxt_last;
    logic [7:0] w_bit;
    logic [7:0] w_nxt_bit;

    assign w_cmd_fire  = (r_state == ST_IDLE) && bus.cmd_valid;
    assign w_cmd_legal = (bus.cmd_tamanho >= 8'd2) && (bus.cmd_tamanho <= 8'(MAX_DIM))
                         && (bus.cmd_opcode != 3'b111);
    assign w_loading   = (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);
    assign w_in_fire   = w_loading && bus.in_valid;
    // out_valid is always high in STORE, so out_ready alone completes a beat
    assign w_out_fire  = (r_state == ST_STORE) && bus.out_ready;

    // One walker serves both load phases and the store phase; it is rewound
    // on command accept and at the end of each operand.
    assign w_cnt_clear = (w_cmd_fire && w_cmd_legal) || (w_in_fire && w_last);
    assign w_cnt_step  = w_in_fire || (w_out_fire && !r_out_last);

    assign w_bit     = {w_idx, 3'b000};
    assign w_nxt_bit = {w_nxt_idx, 3'b000};

    indice_matriz u_indice (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_cnt_clear),
        .i_step     (w_cnt_step),
        .i_n        (r_tamanho[2:0]),
        .o_idx      (w_idx),
        .o_nxt_idx  (w_nxt_idx),
        .o_last     (w_last),
        .o_nxt_last (w_nxt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_matriz1   <= '0;
            r_matriz2   <= '0;
            r_result    <= '0;
            r_opcode    <= '0;
            r_escalar   <= '0;
            r_tamanho   <= '0;
            r_exec      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_erro      <= 1'b0;
        end else begin
            r_erro <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        if (w_cmd_legal) begin
                            r_opcode  <= bus.cmd_opcode;
                            r_tamanho <= bus.cmd_tamanho;
                            r_escalar <= bus.cmd_escalar;
                            r_matriz1 <= '0;
                            r_matriz2 <= '0;
                            r_result  <= '0;
                            r_exec    <= '0;
                            r_state   <= ST_LOAD_A;
                        end else begin
                            r_erro <= 1'b1;
                        end
                    end
                end
                ST_LOAD_A, ST_LOAD_B: begin
                    if (bus.in_valid) begin
                        if (r_state == ST_LOAD_A)
                            r_matriz1[w_bit +: ELEM_W] <= bus.in_data;
                        else
                            r_matriz2[w_bit +: ELEM_W] <= bus.in_data;
                        if (w_last) begin
                            r_exec <= '0;
                            if (r_state == ST_LOAD_A && needs_b(r_opcode))
                                r_state <= ST_LOAD_B;
                            else
                                r_state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (r_exec == EXEC_LAST) begin
                        // First result element is taken straight from the
                        // ULA so it is presented on the first STORE cycle.
                        r_result    <= resultado;
                        r_out_valid <= 1'b1;
                        r_out_data  <= resultado[ELEM_W-1:0];
                        r_out_last  <= (r_opcode == OP_DET);
                        r_state     <= ST_STORE;
                    end else begin
                        r_exec <= r_exec + 4'd1;
                    end
                end
                ST_STORE: begin
                    if (bus.out_ready) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_data  <= '0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_out_data <= r_result[w_nxt_bit +: ELEM_W];
                            r_out_last <= w_nxt_last;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (r_state == ST_IDLE);
    assign bus.in_ready  = w_loading;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;

    assign matriz1 = r_matriz1;
    assign matriz2 = r_matriz2;
    assign opcode  = r_opcode;
    assign escalar = r_escalar;
    assign tamanho = r_tamanho;
    assign busy    = (r_state != ST_IDLE);
    assign erro    = r_erro;

endmodule

// File: tb/tb_ula_load_store.sv
// Bench for ula_load_store: a stand-in ULA drives resultado from the DUT's
// operand outputs; expected result streams come from the bench's own
// stimulus arrays and are checked by a single compare process.
module tb_ula_load_store;
    import ula_pkg::*;

    localparam int unsigned EXEC = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ula_load_store_if bus ();

    logic [199:0] m1, m2, res;
    logic [2:0]   op_o;
    logic [7:0]   esc_o, tam_o;
    logic         busy, erro;

    ula_load_store #(.EXEC_CYCLES(EXEC), .MAX_DIM(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .matriz1   (m1),
        .matriz2   (m2),
        .opcode    (op_o),
        .escalar   (esc_o),
        .tamanho   (tam_o),
        .resultado (res),
        .busy      (busy),
        .erro      (erro)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [8:0] exp_q[$];
    logic [7:0] sa[25];
    logic [7:0] sb[25];
    bit stall_mode = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [199:0] act, input logic [199:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] el(input logic [199:0] m, input int r, input int c);
        return m[(r*5+c)*8 +: 8];
    endfunction

    function automatic logic [7:0] det8(input logic [199:0] a, input logic [7:0] n);
        int d = 0;
        int m[3][3];
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                m[r][c] = int'(el(a, r, c));
        if (n == 8'd2)
            d = m[0][0]*m[1][1] - m[0][1]*m[1][0];
        else if (n == 8'd3)
            d = m[0][0]*(m[1][1]*m[2][2] - m[1][2]*m[2][1])
              - m[0][1]*(m[1][0]*m[2][2] - m[1][2]*m[2][0])
              + m[0][2]*(m[1][0]*m[2][1] - m[1][1]*m[2][0]);
        return d[7:0];
    endfunction

    // Stand-in ULA arithmetic on 5x5 byte matrices (results mod 256).
    function automatic logic [199:0] ula_ref(input logic [199:0] a, input logic [199:0] b,
                                             input logic [2:0] op, input logic [7:0] esc,
                                             input logic [7:0] n);
        logic [199:0] o = '0;
        int s;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                s = 0;
                case (op)
                    3'b000: s = int'(el(a, r, c)) + int'(el(b, r, c));
                    3'b001: s = int'(el(a, r, c)) - int'(el(b, r, c));
                    3'b010: for (int k = 0; k < 5; k++) s += int'(el(a, r, k)) * int'(el(b, k, c));
                    3'b011: s = int'(el(a, r, c)) * int'(esc);
                    3'b100: s = int'(el(a, c, r));
                    3'b101: s = -int'(el(a, r, c));
                    default: s = 0;
                endcase
                o[(r*5+c)*8 +: 8] = s[7:0];
            end
        end
        if (op == 3'b110) o[7:0] = det8(a, n);
        return o;
    endfunction

    function automatic logic [199:0] pack(input int n, input logic [7:0] v[25]);
        logic [199:0] p = '0;
        for (int i = 0; i < n*n; i++)
            p[((i/n)*5 + i%n)*8 +: 8] = v[i];
        return p;
    endfunction

    assign res = ula_ref(m1, m2, op_o, esc_o, tam_o);

    // out_ready: always 1, or the repeating 1,0,0,1 pattern in stall mode
    initial begin
        int unsigned ph = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = stall_mode ? ((ph % 4 == 0) || (ph % 4 == 3)) : 1'b1;
            ph++;
        end
    end

    // Compare process: result stream against the expected queue, plus hold
    // checks while stalled.
    initial begin
        logic [8:0] e;
        logic       stalled = 1'b0;
        logic [7:0] held_d = '0;
        logic       held_l = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("hold_valid", 32'(bus.out_valid), 1);
                    chk("hold_data", 32'(bus.out_data), 32'(held_d));
                    chk("hold_last", 32'(bus.out_last), 32'(held_l));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_out", 32'(bus.out_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", 32'(bus.out_data), 32'(e[7:0]));
                        chk("out_last", 32'(bus.out_last), 32'(e[8]));
                    end
                end
                stalled = bus.out_valid && !bus.out_ready;
                held_d  = bus.out_data;
                held_l  = bus.out_last;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic start_op(input logic [2:0] op, input int n, input logic [7:0] esc, input bit ok);
        logic [199:0] r;
        if (ok) begin
            r = ula_ref(pack(n, sa), (op <= 3'b010) ? pack(n, sb) : '0, op, esc, 8'(n));
            if (op == 3'b110) begin
                exp_q.push_back({1'b1, el(r, 0, 0)});
            end else begin
                for (int i = 0; i < n*n; i++)
                    exp_q.push_back({(i == n*n-1), el(r, i/n, i%n)});
            end
        end
        bus.cmd_valid   = 1'b1;
        bus.cmd_opcode  = op;
        bus.cmd_tamanho = 8'(n);
        bus.cmd_escalar = esc;
        @(negedge clk);
        chk("cmd_ready_idle", 32'(bus.cmd_ready), 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        if (ok) begin
            chk("accept_flags", 32'({bus.cmd_ready, bus.in_ready, busy, erro}), 32'b0110);
            chk("cmd_regs", 32'({op_o, esc_o, tam_o}), 32'({op, esc, 8'(n)}));
            chkw("m1_cleared", m1, '0);
        end else begin
            chk("reject_flags", 32'({bus.cmd_ready, bus.in_ready, busy, erro}), 32'b1001);
            @(negedge clk);
            chk("erro_pulse_end", 32'(erro), 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic put_elem(input logic [7:0] v);
        int unsigned k = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        @(negedge clk);
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_wait", 32'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic load(input int n, input bit second);
        for (int i = 0; i < n*n; i++)
            put_elem(second ? sb[i] : sa[i]);
    endtask

    task automatic finish_op();
        int unsigned k = 0;
        while ((busy || exp_q.size() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("queue_left", 32'(exp_q.size()), 0);
        chk("busy_end", 32'(busy), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [199:0] lit;
        #200000;
        lit = '0;
        $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [199:0] lit;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_opcode = '0; bus.cmd_tamanho = '0; bus.cmd_escalar = '0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_flags", 32'({bus.cmd_ready, bus.in_ready, bus.out_valid, bus.out_last, busy, erro}), 32'b100000);
        chk("reset_regs", 32'({bus.out_data, op_o, esc_o, tam_o}), 0);
        chkw("reset_m1", m1, '0);
        chkw("reset_m2", m2, '0);
        @(posedge clk);
        #1;

        // n=2 add: matriz1 layout and 11,22,33,44
        for (int i = 0; i < 25; i++) begin sa[i] = 8'(i+1); sb[i] = 8'(10*(i+1)); end
        chk("pin_sum", 32'(el(ula_ref(pack(2, sa), pack(2, sb), OP_SOMA, 0, 2), 1, 1)), 44);
        start_op(OP_SOMA, 2, 8'd0, 1'b1);
        load(2, 1'b0);
        lit = '0;
        lit[7:0] = 8'd1; lit[15:8] = 8'd2; lit[47:40] = 8'd3; lit[55:48] = 8'd4;
        chkw("m1_layout", m1, lit);
        load(2, 1'b1);
        finish_op();

        // n=3 scalar: 9 elements only, latency, cmd/in ignored outside IDLE/LOAD
        for (int i = 0; i < 25; i++) begin sa[i] = 8'(i+1); sb[i] = 8'hEE; end
        chk("pin_esc", 32'(el(ula_ref(pack(3, sa), '0, OP_ESC, 2, 3), 2, 2)), 18);
        start_op(OP_ESC, 3, 8'd2, 1'b1);
        load(3, 1'b0);
        bus.cmd_valid = 1'b1; bus.cmd_opcode = 3'b111; bus.cmd_tamanho = 8'd9;
        bus.in_valid = 1'b1; bus.in_data = 8'hFF;
        for (int k = 1; k <= int'(EXEC) + 1; k++) begin
            @(negedge clk);
            chk("exec_in_ready", 32'(bus.in_ready), 0);
            chk("exec_cmd_ready", 32'(bus.cmd_ready), 0);
            chk("exec_erro", 32'(erro), 0);
            chk("ov_latency", 32'(bus.out_valid), (k == int'(EXEC) + 1) ? 1 : 0);
        end
        bus.cmd_valid = 1'b0;
        bus.in_valid  = 1'b0;
        chkw("esc_m1", m1, pack(3, sa));
        chkw("esc_m2_zero", m2, '0);
        @(posedge clk);
        #1;
        finish_op();

        // illegal commands leave registers alone
        start_op(OP_SOMA, 6, 8'd0, 1'b0);
        start_op(3'b111, 3, 8'd0, 1'b0);
        start_op(OP_SOMA, 1, 8'd0, 1'b0);
        chk("held_cmd_regs", 32'({op_o, esc_o, tam_o}), 32'({OP_ESC, 8'd2, 8'd3}));

        // determinant n=3: single element
        for (int i = 0; i < 25; i++) sa[i] = (i % 4 == 0) ? 8'(i/4 + 2) : 8'd0;
        chk("pin_det", 32'(el(ula_ref(pack(3, sa), '0, OP_DET, 0, 3), 0, 0)), 24);
        start_op(OP_DET, 3, 8'd0, 1'b1);
        load(3, 1'b0);
        finish_op();

        // stalled output, n=2 subtract
        for (int i = 0; i < 25; i++) begin sa[i] = 8'(50 - 10*i); sb[i] = 8'(5 + 5*i); end
        chk("pin_sub", 32'(el(ula_ref(pack(2, sa), pack(2, sb), OP_SUB, 0, 2), 0, 0)), 45);
        stall_mode = 1'b1;
        start_op(OP_SUB, 2, 8'd0, 1'b1);
        load(2, 1'b0);
        load(2, 1'b1);
        finish_op();
        stall_mode = 1'b0;

        // n=2 matrix product
        for (int i = 0; i < 25; i++) begin sa[i] = 8'(i+1); sb[i] = 8'(i+5); end
        chk("pin_mul", 32'(el(ula_ref(pack(2, sa), pack(2, sb), OP_MUL, 0, 2), 1, 0)), 43);
        start_op(OP_MUL, 2, 8'd0, 1'b1);
        load(2, 1'b0);
        load(2, 1'b1);
        finish_op();

        // n=5 transpose (full layout)
        for (int i = 0; i < 25; i++) sa[i] = 8'(i+1);
        chk("pin_transp", 32'(el(ula_ref(pack(5, sa), '0, OP_TRANSP, 0, 5), 0, 1)), 6);
        start_op(OP_TRANSP, 5, 8'd0, 1'b1);
        load(5, 1'b0);
        finish_op();

        // reset mid-LOAD_B, then a fresh command
        for (int i = 0; i < 25; i++) begin sa[i] = 8'(i+1); sb[i] = 8'(i+2); end
        start_op(OP_SOMA, 2, 8'd0, 1'b1);
        load(2, 1'b0);
        put_elem(sb[0]);
        put_elem(sb[1]);
        rst = 1'b1;
        @(negedge clk);
        chkw("rst_m1", m1, '0);
        chkw("rst_m2", m2, '0);
        chk("rst_flags", 32'({bus.cmd_ready, bus.in_ready, bus.out_valid, busy}), 32'b1000);
        exp_q.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 25; i++) begin sa[i] = 8'(3*i+1); sb[i] = 8'(7*i); end
        start_op(OP_SOMA, 2, 8'd0, 1'b1);
        load(2, 1'b0);
        load(2, 1'b1);
        finish_op();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
